msrv_32_fetch_unit: RTL

MSRV_32_FETCH_UNIT -- requirements
Module: msrv_32_fetch_unit

---
 rtl/msrv_32_pkg.sv | 14 +
 rtl/msrv_32_pc_gen.sv | 34 +++
 rtl/msrv_32_fetch_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/msrv_32_pkg.sv
// Shared definitions for the msrv_32 instruction fetch path.
package msrv_32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;

endpackage

// File: rtl/msrv_32_pc_gen.sv
// Program counter: +4 increment, redirect load and target alignment check.
module msrv_32_pc_gen
    import msrv_32_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = DEFAULT_BOOT_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_inc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic        misaligned,
    output logic        target_misaligned
);

    assign target_misaligned = (redirect_pc[1:0] != 2'b00);

    // A misaligned target leaves the PC untouched; only the flag records it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= BOOT_ADDR;
            misaligned <= 1'b0;
        end else if (redirect) begin
            misaligned <= target_misaligned;
            if (!target_misaligned) begin
                pc <= redirect_pc;
            end
        end else if (pc_inc) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/msrv_32_fetch_unit.sv
// Instruction fetch unit: single outstanding request, output register plus
// one-entry skid buffer, redirect handling with in-flight response drop.
module msrv_32_fetch_unit
    import msrv_32_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = DEFAULT_BOOT_ADDR
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_n_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_gnt_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    input  logic        stall_in,
    output logic        instr_valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        misaligned_out
);

    fetch_state_t state_q, state_d;

    logic [31:0] pc;
    logic        pc_inc;
    logic        target_misaligned;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        valid_q, valid_d;
    logic        drop_q, drop_d;

    msrv_32_pc_gen #(
        .BOOT_ADDR(BOOT_ADDR)
    ) u_pc_gen (
        .clk               (ms_riscv32_mp_clk_in),
        .rst_n             (ms_riscv32_mp_rst_n_in),
        .pc_inc            (pc_inc),
        .redirect          (redirect_in),
        .redirect_pc       (redirect_pc_in),
        .pc                (pc),
        .misaligned        (misaligned_out),
        .target_misaligned (target_misaligned)
    );

    // No request during a redirect cycle, so a grant can never be accepted
    // for the PC that is about to be replaced.
    assign imem_req_out    = (state_q == ST_REQ) && !(valid_q && stall_in) && !redirect_in;
    assign imem_addr_out   = pc;
    assign instr_valid_out = valid_q;
    assign instr_out       = instr_q;
    assign pc_out          = pc_out_q;

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        valid_d      = valid_q && stall_in;
        drop_d       = drop_q;
        pc_inc       = 1'b0;

        if (redirect_in) begin
            valid_d = 1'b0;
            if (target_misaligned) begin
                state_d = ST_IDLE;
                drop_d  = 1'b0;
            end else if ((state_q == ST_WAIT) && !imem_rvalid_in) begin
                // Response still in flight: wait for it and throw it away.
                state_d = ST_WAIT;
                drop_d  = 1'b1;
            end else begin
                state_d = ST_REQ;
                drop_d  = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!misaligned_out) begin
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (imem_req_out && imem_gnt_in) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid_in) begin
                        state_d = ST_REQ;
                        if (drop_q) begin
                            drop_d = 1'b0;
                        end else begin
                            pc_inc = 1'b1;
                            if (!valid_q || !stall_in) begin
                                instr_d  = imem_rdata_in;
                                pc_out_d = pc;
                                valid_d  = 1'b1;
                            end else begin
                                skid_instr_d = imem_rdata_in;
                                skid_pc_d    = pc;
                                state_d      = ST_HOLD;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall_in) begin
                        instr_d  = skid_instr_q;
                        pc_out_d = skid_pc_q;
                        valid_d  = 1'b1;
                        state_d  = ST_REQ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            instr_q      <= NOP_INSTR;
            pc_out_q     <= BOOT_ADDR;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            valid_q      <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            valid_q      <= valid_d;
            drop_q       <= drop_d;
        end
    end

endmodule
